// File: rtl/chaos_xor_cipher.sv
// chaos_xor_cipher
// Paces the triplet reader with a one-cycle enable_read pulse, captures the
// three returned words, and XORs each with a keystream from a Q0.32
// fixed-point logistic map (x <- 4*x*(1-x)). The encrypted triplet is held
// on a valid/ready port until accepted. This repeats for TRIPLETS triplets
// per frame.
// Optional feature: define CHAOS_DIFFUSION_EN to chain each cipher word into
// the next one (c_k = p_k ^ f(x) ^ chain). Without it the block is a plain
// stream cipher with no chain register.

module chaos_xor_cipher #(
   parameter logic [31:0] SEED     = 32'h1234_5678,
   parameter int          TRIPLETS = 300
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        enable_read,
   input  logic [31:0] val1,
   input  logic [31:0] val2,
   input  logic [31:0] val3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_d0,
   output logic [31:0] out_d1,
   output logic [31:0] out_d2,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_CAPT,
      S_ITER,
      S_OUT
   } state_t;

   localparam logic [8:0] LAST_IDX = 9'(TRIPLETS - 1);

   state_t           state_q, state_d;
   logic [31:0]      x_q, x_d;
   logic [8:0]       cnt_q, cnt_d;
   logic [1:0]       k_q, k_d;
   logic [2:0][31:0] p_q, p_d;
   logic [2:0][31:0] c_q, c_d;
   logic             done_q, done_d;
`ifdef CHAOS_DIFFUSION_EN
   logic [31:0]      chain_q, chain_d;
`endif

   logic [32:0] one_minus_x;
   logic [32:0] r;
   logic [31:0] fx;
   logic [31:0] ks_word;
   logic [31:0] p_sel;
   logic [31:0] cipher_word;

   // Logistic map step: r = (x*(2^32-x))[62:30]; saturate at 1.0, and
   // reseed instead of falling into the zero fixed point.
   always_comb begin
      one_minus_x = 33'h1_0000_0000 - {1'b0, x_q};
      r           = 33'((64'(x_q) * 64'(one_minus_x)) >> 30);
      fx          = r[31:0];
      if (r[32]) begin
         fx = 32'hFFFF_FFFF;
      end else if (r[31:0] == 32'd0) begin
         fx = SEED;
      end
   end

`ifdef CHAOS_DIFFUSION_EN
   assign ks_word = fx ^ chain_q;
`else
   assign ks_word = fx;
`endif

   // Select the plaintext word being encrypted in the current ITER cycle.
   always_comb begin
      case (k_q)
         2'd0:    p_sel = p_q[0];
         2'd1:    p_sel = p_q[1];
         default: p_sel = p_q[2];
      endcase
      cipher_word = p_sel ^ ks_word;
   end

   // Next-state logic: frame sequencing, capture, keystream and handshake.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      p_d     = p_q;
      c_d     = c_q;
      done_d  = 1'b0;
`ifdef CHAOS_DIFFUSION_EN
      chain_d = chain_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_REQ;
`ifdef CHAOS_DIFFUSION_EN
               chain_d = 32'd0;
`endif
            end
         end
         S_REQ: begin
            state_d = S_CAPT;
         end
         S_CAPT: begin
            p_d[0]  = val1;
            p_d[1]  = val2;
            p_d[2]  = val3;
            k_d     = 2'd0;
            state_d = S_ITER;
         end
         S_ITER: begin
            x_d = fx;
            case (k_q)
               2'd0:    c_d[0] = cipher_word;
               2'd1:    c_d[1] = cipher_word;
               default: c_d[2] = cipher_word;
            endcase
`ifdef CHAOS_DIFFUSION_EN
            chain_d = cipher_word;
`endif
            if (k_q == 2'd2) begin
               k_d     = 2'd0;
               state_d = S_OUT;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = 9'd0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = cnt_q + 9'd1;
                  state_d = S_REQ;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset reloads the map seed and clears everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= SEED;
         cnt_q   <= 9'd0;
         k_q     <= 2'd0;
         p_q     <= '0;
         c_q     <= '0;
         done_q  <= 1'b0;
`ifdef CHAOS_DIFFUSION_EN
         chain_q <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         p_q     <= p_d;
         c_q     <= c_d;
         done_q  <= done_d;
`ifdef CHAOS_DIFFUSION_EN
         chain_q <= chain_d;
`endif
      end
   end

   assign enable_read = (state_q == S_REQ);
   assign out_valid   = (state_q == S_OUT);
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign out_d0      = c_q[0];
   assign out_d1      = c_q[1];
   assign out_d2      = c_q[2];

endmodule

// File: tb/tb_chaos_xor_cipher.sv
// Testbench for chaos_xor_cipher: emulates the triplet reader, drives the
// output handshake, and checks every triplet against a behavioural model
// of the logistic-map keystream.

module tb_chaos_xor_cipher;

   localparam logic [31:0] TB_SEED     = 32'h8000_0000;
   localparam int          TB_TRIPLETS = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic        enable_read;
   logic [31:0] val1, val2, val3;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_d0, out_d1, out_d2;
   logic        busy;
   logic        done;

   int checkCount = 0;
   int failCount  = 0;

   logic [31:0] xModel;
   logic [31:0] chainModel;
   logic [31:0] expQ[$];
   int          readCount;
   int          tripInFrame;
   bit          zeroData;
   bit          freshReset;

   chaos_xor_cipher #(
      .SEED     (TB_SEED),
      .TRIPLETS (TB_TRIPLETS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .enable_read (enable_read),
      .val1        (val1),
      .val2        (val2),
      .val3        (val3),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_d0      (out_d0),
      .out_d1      (out_d1),
      .out_d2      (out_d2),
      .busy        (busy),
      .done        (done)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count and report one comparison.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Logistic map in real-number terms: x' = 4x(1-x) scaled to 2^32,
   // saturated at 1.0 and reseeded when it collapses to zero.
   function automatic logic [31:0] mapStep(input logic [31:0] x);
      longint unsigned xv, m, r;
      logic [31:0] res;
      xv = 64'(x);
      m  = xv * (64'h1_0000_0000 - xv);
      r  = m / 64'h4000_0000;
      if (r >= 64'h1_0000_0000) res = 32'hFFFF_FFFF;
      else if (r == 0)          res = TB_SEED;
      else                      res = 32'(r);
      return res;
   endfunction

   // Reader emulation: new data appears after each enable_read pulse, and
   // the expected cipher words are queued immediately.
   initial begin
      logic [31:0] pw[3];
      val1 = '0; val2 = '0; val3 = '0;
      forever begin
         @(negedge clk);
         if (enable_read) begin
            readCount++;
            checkOutput("read_while_valid", 32'(out_valid), 32'd0);
            for (int i = 0; i < 3; i++) pw[i] = zeroData ? 32'd0 : $urandom;
            val1 = pw[0]; val2 = pw[1]; val3 = pw[2];
            if (tripInFrame == 0) chainModel = 32'd0;
            tripInFrame++;
            for (int i = 0; i < 3; i++) begin
               logic [31:0] c;
               xModel = mapStep(xModel);
               c = pw[i] ^ xModel;
`ifdef CHAOS_DIFFUSION_EN
               c = c ^ chainModel;
               chainModel = c;
`endif
               expQ.push_back(c);
            end
         end
      end
   end

   // Run one frame. mode 0: ready held high, 1: random ready,
   // 2: 10-cycle stall on the first triplet. abortAt>0 returns at that cycle.
   task automatic applyStimulus(input int mode, input bit midStart, input int abortAt);
      int          firstValidN = 0;
      int          accepted    = 0;
      int          stallLeft   = 0;
      int          unstable    = 0;
      int          readSnap    = 0;
      bit          stallStarted = 0;
      bit          doneSeen    = 0;
      logic [31:0] snap[3];
      logic [31:0] e[3];
      tripInFrame = 0;
      readCount   = 0;
      start = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         start = midStart ? (n == 10) : 1'b0;
         if (abortAt != 0 && n == abortAt) return;
         if (out_valid && firstValidN == 0) begin
            firstValidN = n;
            checkOutput("first_valid_cycle", 32'(n), 32'd6);
         end
         if (mode == 2 && out_valid && !stallStarted) begin
            stallStarted = 1;
            stallLeft = 10;
            snap[0] = out_d0; snap[1] = out_d1; snap[2] = out_d2;
            readSnap = readCount;
         end
         if (stallLeft > 0) begin
            out_ready = 1'b0;
            if (!out_valid || out_d0 !== snap[0] || out_d1 !== snap[1] || out_d2 !== snap[2])
               unstable++;
            stallLeft--;
            if (stallLeft == 0) begin
               checkOutput("stall_stable", 32'(unstable), 32'd0);
               checkOutput("stall_no_read", 32'(readCount - readSnap), 32'd0);
            end
         end else if (mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            for (int i = 0; i < 3; i++) e[i] = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
            checkOutput("out_d0", out_d0, e[0]);
            checkOutput("out_d1", out_d1, e[1]);
            checkOutput("out_d2", out_d2, e[2]);
            if (zeroData && freshReset && accepted == 0) begin
`ifdef CHAOS_DIFFUSION_EN
               checkOutput("seed_d0", out_d0, 32'hFFFF_FFFF);
               checkOutput("seed_d1", out_d1, 32'hFFFF_FFFC);
               checkOutput("seed_d2", out_d2, 32'hFFFF_FFF7);
`else
               checkOutput("seed_d0", out_d0, 32'hFFFF_FFFF);
               checkOutput("seed_d1", out_d1, 32'h0000_0003);
               checkOutput("seed_d2", out_d2, 32'h0000_000B);
`endif
               freshReset = 0;
            end
            accepted++;
         end
         if (done) begin
            doneSeen = 1;
            if (mode == 0) checkOutput("done_cycle", 32'(n), 32'd25);
            checkOutput("busy_at_done", 32'(busy), 32'd0);
            checkOutput("reads_per_frame", 32'(readCount), 32'(TB_TRIPLETS));
            checkOutput("accepts_per_frame", 32'(accepted), 32'(TB_TRIPLETS));
            break;
         end
      end
      start = 1'b0;
      if (!doneSeen) begin
         checkOutput("done_timeout", 32'd0, 32'd1);
      end else begin
         @(negedge clk);
         checkOutput("done_single_pulse", 32'(done), 32'd0);
         checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      end
   endtask

   // Check that every output sits at its reset value.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_enable_read"}, 32'(enable_read), 32'd0);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_out_d0"}, out_d0, 32'd0);
      checkOutput({tag, "_out_d1"}, out_d1, 32'd0);
      checkOutput({tag, "_out_d2"}, out_d2, 32'd0);
   endtask

   // Main sequence: reset, directed seed frame, stall frame, random frames,
   // mid-ITER reset and a replay from the seed.
   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      out_ready  = 1'b0;
      zeroData   = 1;
      freshReset = 1;
      xModel     = TB_SEED;
      chainModel = 32'd0;
      readCount  = 0;
      tripInFrame = 0;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(0, 1, 0);
      zeroData = 0;
      applyStimulus(2, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);

      applyStimulus(0, 0, 4);
      #3 rst = 1'b1;
      #1 checkResetOutputs("midreset");
      xModel     = TB_SEED;
      chainModel = 32'd0;
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      zeroData   = 1;
      freshReset = 1;
      applyStimulus(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
